// File: rtl/updown_count_param.sv
// updown_count_param
//   Parameterised up/down counter with four counting modes, synchronous
//   preset and parallel load, and a one-cycle terminal-count pulse.
//
// Parameters
//   WIDTH : counter width in bits (2..32)
//   MAX   : upper count limit (1 .. 2**WIDTH-1)
//   STEP  : increment/decrement amount (1 .. MAX)
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset: count=0, dir=1, tc=0
//   preset in   synchronous load of MAX, direction set to down
//   load   in   synchronous parallel load of din (clamped to MAX)
//   din    in   parallel load value
//   en     in   count enable
//   mode   in   00 up-wrap, 01 down-wrap, 10 bounce, 11 up-saturate
//   count  out  registered count value
//   dir    out  registered direction (1 = up, 0 = down); this is the
//               only piece of control state, so it doubles as the
//               observable state of the bounce sequencer
//   tc     out  registered one-cycle terminal-count pulse
//
// Edge priority: preset > load > enabled count > hold.
module updown_count_param #(
  parameter int unsigned         WIDTH = 5,
  parameter logic [WIDTH-1:0]    MAX   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0]    STEP  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             preset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc
);

  typedef enum logic [1:0] {
    MODE_UP_WRAP   = 2'b00,
    MODE_DOWN_WRAP = 2'b01,
    MODE_BOUNCE    = 2'b10,
    MODE_UP_SAT    = 2'b11
  } mode_e;

  // All next-count arithmetic is done one bit wider than the counter so
  // that count+STEP can never wrap before it is compared against MAX.
  localparam logic [WIDTH:0] MAX_X  = {1'b0, MAX};
  localparam logic [WIDTH:0] STEP_X = {1'b0, STEP};

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;

  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_diff;
  logic [WIDTH:0]   wrap_lim;
  mode_e            mode_s;

  assign cnt_x    = {1'b0, count_q};
  assign up_sum   = cnt_x + STEP_X;
  // Only consumed when cnt_x >= STEP_X, so it never underflows in use.
  assign dn_diff  = cnt_x - STEP_X;
  // STEP <= MAX, so this is never negative.
  assign wrap_lim = MAX_X - STEP_X;
  assign mode_s   = mode_e'(mode);

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;

    if (preset) begin
      count_d = MAX;
      dir_d   = 1'b0;
    end else if (load) begin
      // Clamp so values above MAX can never enter the counter.
      count_d = (din > MAX) ? MAX : din;
    end else if (en) begin
      unique case (mode_s)
        MODE_UP_WRAP: begin
          dir_d = 1'b1;
          if (cnt_x > wrap_lim) begin
            count_d = '0;
            tc_d    = 1'b1;
          end else begin
            count_d = up_sum[WIDTH-1:0];
          end
        end
        MODE_DOWN_WRAP: begin
          dir_d = 1'b0;
          if (cnt_x < STEP_X) begin
            count_d = MAX;
            tc_d    = 1'b1;
          end else begin
            count_d = dn_diff[WIDTH-1:0];
          end
        end
        MODE_BOUNCE: begin
          // The held dir picks the starting direction after a mode change.
          if (dir_q) begin
            if (up_sum >= MAX_X) begin
              count_d = MAX;
              dir_d   = 1'b0;
              tc_d    = 1'b1;
            end else begin
              count_d = up_sum[WIDTH-1:0];
            end
          end else begin
            if (cnt_x <= STEP_X) begin
              count_d = '0;
              dir_d   = 1'b1;
              tc_d    = 1'b1;
            end else begin
              count_d = dn_diff[WIDTH-1:0];
            end
          end
        end
        MODE_UP_SAT: begin
          dir_d = 1'b1;
          // Already saturated: hold without re-pulsing tc.
          if (cnt_x == MAX_X) begin
            count_d = count_q;
          end else if (up_sum >= MAX_X) begin
            count_d = MAX;
            tc_d    = 1'b1;
          end else begin
            count_d = up_sum[WIDTH-1:0];
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      dir_q   <= 1'b1;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_updown_count_param.sv
// tb_updown_count_param
//   Self-checking bench for updown_count_param with WIDTH=5, MAX=19, STEP=3.
//   Directed sequences for the documented scenarios, then randomized
//   stimulus compared against an integer reference model.
module tb_updown_count_param;

  localparam int W    = 5;
  localparam int MAXV = 19;
  localparam int STPV = 3;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         preset, load, en;
  logic [W-1:0] din;
  logic [1:0]   mode;
  logic [W-1:0] count;
  logic         dir, tc;

  always #5 clk = ~clk;

  updown_count_param #(
    .WIDTH(W),
    .MAX  (5'd19),
    .STEP (5'd3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .preset(preset),
    .load  (load),
    .din   (din),
    .en    (en),
    .mode  (mode),
    .count (count),
    .dir   (dir),
    .tc    (tc)
  );

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];

  // Reference state, plain integers.
  int m_count = 0;
  int m_dir   = 1;
  int m_tc    = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one rising edge, from the rule table in words.
  task automatic model_edge(input bit p, input bit l, input int d,
                            input bit e, input int md);
    m_tc = 0;
    if (p) begin
      m_count = MAXV;
      m_dir   = 0;
    end else if (l) begin
      m_count = (d > MAXV) ? MAXV : d;
    end else if (e) begin
      case (md)
        0: begin
          m_dir = 1;
          if (m_count + STPV > MAXV) begin m_count = 0; m_tc = 1; end
          else m_count = m_count + STPV;
        end
        1: begin
          m_dir = 0;
          if (m_count - STPV < 0) begin m_count = MAXV; m_tc = 1; end
          else m_count = m_count - STPV;
        end
        2: begin
          if (m_dir == 1) begin
            if (m_count + STPV >= MAXV) begin
              m_count = MAXV; m_dir = 0; m_tc = 1;
            end else m_count = m_count + STPV;
          end else begin
            if (m_count - STPV <= 0) begin
              m_count = 0; m_dir = 1; m_tc = 1;
            end else m_count = m_count - STPV;
          end
        end
        default: begin
          m_dir = 1;
          if (m_count != MAXV) begin
            if (m_count + STPV >= MAXV) begin m_count = MAXV; m_tc = 1; end
            else m_count = m_count + STPV;
          end
        end
      endcase
    end
    exp_q.push_back(W'(m_count));
  endtask

  task automatic model_reset();
    m_count = 0;
    m_dir   = 1;
    m_tc    = 0;
  endtask

  task automatic check_state(input string tag);
    logic [W-1:0] exp_c;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      exp_c = exp_q.pop_front();
      check({tag, "_count"}, 32'(count), 32'(exp_c));
    end
    check({tag, "_dir"}, 32'(dir), 32'(m_dir));
    check({tag, "_tc"},  32'(tc),  32'(m_tc));
    check({tag, "_range"}, 32'(count <= W'(MAXV)), 32'd1);
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; drives, waits one edge, samples at posedge+1.
  task automatic drive_cycle(input string tag, input bit p, input bit l,
                             input int d, input bit e, input int md);
    preset = p;
    load   = l;
    din    = W'(d);
    en     = e;
    mode   = 2'(md);
    @(posedge clk);
    model_edge(p, l, d, e, md);
    #1;
    check_state(tag);
  endtask

  // Asserts reset between edges with every control input active, checks
  // the immediate effect, holds it across one edge, then releases.
  task automatic async_reset_pulse(input string tag);
    preset = 1'b1;
    load   = 1'b1;
    en     = 1'b1;
    din    = W'(7);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check({tag, "_async_count"}, 32'(count), 32'd0);
    check({tag, "_async_dir"},   32'(dir),   32'd1);
    check({tag, "_async_tc"},    32'(tc),    32'd0);
    @(posedge clk);
    #1;
    check({tag, "_hold_count"}, 32'(count), 32'd0);
    check({tag, "_hold_dir"},   32'(dir),   32'd1);
    reset  = 1'b0;
    preset = 1'b0;
    load   = 1'b0;
    en     = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int exp_up[7]     = '{3, 6, 9, 12, 15, 18, 0};
  int exp_bounce[10] = '{18, 19, 16, 13, 10, 7, 4, 1, 0, 3};
  int exp_bdir[10]   = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 1};
  int exp_btc[10]    = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
  int exp_sat[4]     = '{18, 19, 19, 19};
  int exp_sat_tc[4]  = '{0, 1, 0, 0};

  initial begin
    reset  = 1'b1;
    preset = 1'b0;
    load   = 1'b0;
    en     = 1'b0;
    din    = '0;
    mode   = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", 32'(count), 32'd0);
    check("reset_dir",   32'(dir),   32'd1);
    check("reset_tc",    32'(tc),    32'd0);
    reset = 1'b0;

    // Async reset while count=10.
    drive_cycle("ld10", 0, 1, 10, 0, 0);
    check("ld10_const", 32'(count), 32'd10);
    async_reset_pulse("rst_mid");

    // Up-wrap from 0.
    for (int i = 0; i < 7; i++) begin
      drive_cycle("upwrap", 0, 0, 0, 1, 0);
      check("upwrap_const", 32'(count), 32'(exp_up[i]));
      check("upwrap_tc_const", 32'(tc), (i == 6) ? 32'd1 : 32'd0);
    end

    // Down-wrap after loading 2.
    drive_cycle("dn_ld", 0, 1, 2, 0, 1);
    drive_cycle("dnwrap0", 0, 0, 0, 1, 1);
    check("dnwrap0_const", 32'(count), 32'd19);
    check("dnwrap0_tc_const", 32'(tc), 32'd1);
    drive_cycle("dnwrap1", 0, 0, 0, 1, 1);
    check("dnwrap1_const", 32'(count), 32'd16);
    drive_cycle("dnwrap2", 0, 0, 0, 1, 1);
    check("dnwrap2_const", 32'(count), 32'd13);
    check("dnwrap2_tc_const", 32'(tc), 32'd0);

    // Bounce from 15 going up (reset restores dir=1).
    async_reset_pulse("rst_b");
    drive_cycle("b_ld", 0, 1, 15, 0, 2);
    for (int i = 0; i < 10; i++) begin
      drive_cycle("bounce", 0, 0, 0, 1, 2);
      check("bounce_const", 32'(count), 32'(exp_bounce[i]));
      check("bounce_dir_const", 32'(dir), 32'(exp_bdir[i]));
      check("bounce_tc_const", 32'(tc), 32'(exp_btc[i]));
    end

    // Preset beats load; load clamps above MAX.
    drive_cycle("pre_ld", 1, 1, 7, 1, 0);
    check("pre_ld_const", 32'(count), 32'd19);
    check("pre_ld_dir_const", 32'(dir), 32'd0);
    drive_cycle("ld30", 0, 1, 30, 0, 0);
    check("ld30_const", 32'(count), 32'd19);

    // Up-saturate from 15, then hold with en=0.
    drive_cycle("sat_ld", 0, 1, 15, 0, 3);
    for (int i = 0; i < 4; i++) begin
      drive_cycle("sat", 0, 0, 0, 1, 3);
      check("sat_const", 32'(count), 32'(exp_sat[i]));
      check("sat_tc_const", 32'(tc), 32'(exp_sat_tc[i]));
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle("sat_hold", 0, 0, 0, 0, 3);
      check("sat_hold_const", 32'(count), 32'd19);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset_pulse("rnd_rst");
      end else begin
        drive_cycle("rnd",
                    ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 11) == 0),
                    int'($urandom_range(0, 31)),
                    ($urandom_range(0, 7) != 0),
                    int'($urandom_range(0, 3)));
      end
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    tests_failed++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
